// File: rtl/du_vec.sv
// du_vec: multi-lane log2-domain divider, exponent = log2|F| - log2|D| (Mitchell approximation).
// Optional beat/stall counters are enabled by defining DU_VEC_PERF_CNT_EN.
module du_vec #(
   parameter int W     = 32,
   parameter int Q     = 26,
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   output logic               ready_in,
   input  logic               mode,
   input  logic [LANES*W-1:0] F,
   input  logic [LANES*W-1:0] s_xi,
   output logic               valid_out,
   input  logic               ready_out,
   output logic [LANES*W-1:0] exponent,
   output logic [LANES-1:0]   result_sign,
   output logic [LANES-1:0]   zero_flag,
   output logic [LANES-1:0]   dbz_flag
`ifdef DU_VEC_PERF_CNT_EN
   ,
   output logic [31:0]        beat_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   localparam int PW = $clog2(W);
   localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
      if (x == SMIN) return SMAX;
      return x[W-1] ? -x : x;
   endfunction

   function automatic logic [PW-1:0] lead_one(input logic [W-1:0] x);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < W-1; i++)
         if (x[i]) p = PW'(i);
      return p;
   endfunction

   // Normalise so the leading one sits at bit W-2; the Q bits beneath it are the fraction.
   function automatic logic [W-1:0] mlog2(input logic [W-1:0] x, input logic [PW-1:0] p);
      logic [W-1:0] norm;
      logic [Q-1:0] frac;
      logic [W-1:0] ip;
      norm = x << (PW'(W-2) - p);
      frac = norm[W-3 -: Q];
      ip   = W'({1'b0, p}) - W'(Q);
      return (ip << Q) | W'(frac);
   endfunction

   logic          init_q;
   logic          en;
   logic          acc;
   logic [2:0]    v_q;
   logic [W:0]    sum;
   logic [W-1:0]  f_w, d_w;
   logic [W-1:0]  magf_d [LANES];
   logic [W-1:0]  magd_d [LANES];
   logic [2:0]    fl_d   [LANES];
   logic [W-1:0]  magf0_q [LANES], magd0_q [LANES];
   logic [W-1:0]  magf1_q [LANES], magd1_q [LANES];
   logic [PW-1:0] pf1_q [LANES], pd1_q [LANES];
   logic [W-1:0]  lf2_q [LANES], ld2_q [LANES];
   logic [2:0]    fl0_q [LANES], fl1_q [LANES], fl2_q [LANES];

   assign en       = !valid_out || ready_out;
   assign ready_in = en && init_q;
   assign acc      = valid_in && ready_in;

   // Flag bundle per lane: [2] dbz, [1] zero, [0] final result sign.
   always_comb begin
      sum = '0;
      f_w = '0;
      d_w = '0;
      for (int i = 0; i < LANES; i++) begin
         magf_d[i] = '0;
         magd_d[i] = '0;
         fl_d[i]   = '0;
      end
      for (int i = 0; i < LANES; i++) begin
         f_w = F[i*W +: W];
         sum = {s_xi[i*W+W-1], s_xi[i*W +: W]} + ((W+1)'(!mode) << Q);
         if (sum[W] != sum[W-1]) d_w = sum[W] ? SMIN : SMAX;
         else                    d_w = sum[W-1:0];
         magf_d[i] = sat_abs(f_w);
         magd_d[i] = sat_abs(d_w);
         fl_d[i][2] = (d_w == '0);
         fl_d[i][1] = (f_w == '0);
         if (d_w == '0)      fl_d[i][0] = f_w[W-1];
         else if (f_w == '0) fl_d[i][0] = 1'b0;
         else                fl_d[i][0] = f_w[W-1] ^ d_w[W-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q      <= 1'b0;
         v_q         <= '0;
         valid_out   <= 1'b0;
         exponent    <= '0;
         result_sign <= '0;
         zero_flag   <= '0;
         dbz_flag    <= '0;
         for (int i = 0; i < LANES; i++) begin
            magf0_q[i] <= '0;
            magd0_q[i] <= '0;
            magf1_q[i] <= '0;
            magd1_q[i] <= '0;
            pf1_q[i]   <= '0;
            pd1_q[i]   <= '0;
            lf2_q[i]   <= '0;
            ld2_q[i]   <= '0;
            fl0_q[i]   <= '0;
            fl1_q[i]   <= '0;
            fl2_q[i]   <= '0;
         end
      end else begin
         init_q <= 1'b1;
         if (en) begin
            v_q       <= {v_q[1:0], acc};
            valid_out <= v_q[2];
            for (int i = 0; i < LANES; i++) begin
               magf0_q[i] <= magf_d[i];
               magd0_q[i] <= magd_d[i];
               fl0_q[i]   <= fl_d[i];
               magf1_q[i] <= magf0_q[i];
               magd1_q[i] <= magd0_q[i];
               pf1_q[i]   <= lead_one(magf0_q[i]);
               pd1_q[i]   <= lead_one(magd0_q[i]);
               fl1_q[i]   <= fl0_q[i];
               lf2_q[i]   <= mlog2(magf1_q[i], pf1_q[i]);
               ld2_q[i]   <= mlog2(magd1_q[i], pd1_q[i]);
               fl2_q[i]   <= fl1_q[i];
               if (fl2_q[i][2])      exponent[i*W +: W] <= SMAX;
               else if (fl2_q[i][1]) exponent[i*W +: W] <= SMIN;
               else                  exponent[i*W +: W] <= lf2_q[i] - ld2_q[i];
               result_sign[i] <= fl2_q[i][0];
               zero_flag[i]   <= fl2_q[i][1];
               dbz_flag[i]    <= fl2_q[i][2];
            end
         end
      end
   end

`ifdef DU_VEC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (valid_out && ready_out)  beat_cnt  <= beat_cnt + 32'd1;
         if (valid_out && !ready_out) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_du_vec.sv
// Scoreboard bench for du_vec (2 lanes, Q5.26): directed beats, random stream, stall and reset cases.
module tb_du_vec;
   localparam int W  = 32;
   localparam int Q  = 26;
   localparam int LN = 2;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   typedef struct packed {
      logic [LN*W-1:0] ex;
      logic [LN-1:0]   sg;
      logic [LN-1:0]   zf;
      logic [LN-1:0]   dz;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            valid_in, ready_in, mode, valid_out, ready_out;
   logic [LN*W-1:0] F, s_xi, exponent;
   logic [LN-1:0]   result_sign, zero_flag, dbz_flag;
`ifdef DU_VEC_PERF_CNT_EN
   logic [31:0]     beat_cnt, stall_cnt;
`endif

   du_vec #(.W(W), .Q(Q), .LANES(LN)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in), .mode(mode),
      .F(F), .s_xi(s_xi), .valid_out(valid_out), .ready_out(ready_out),
      .exponent(exponent), .result_sign(result_sign), .zero_flag(zero_flag), .dbz_flag(dbz_flag)
`ifdef DU_VEC_PERF_CNT_EN
      , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   out_cnt = 0;
   int   stall_tb = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Mitchell log2 of a positive integer magnitude, in Q fixed point.
   function automatic longint mlog(input longint m);
      int p;
      p = 0;
      while ((m >> (p+1)) != 0) p++;
      return (longint'(p - Q) <<< Q) + (((m - (64'sd1 <<< p)) <<< Q) >>> p);
   endfunction

   function automatic exp_t model(input logic [LN*W-1:0] f, input logic [LN*W-1:0] s, input logic m);
      exp_t e;
      longint fv, dv, fm, dm;
      e = '0;
      for (int i = 0; i < LN; i++) begin
         fv = longint'($signed(f[i*W +: W]));
         dv = longint'($signed(s[i*W +: W])) + (m ? 64'sd0 : (64'sd1 <<< Q));
         if (dv > MAXV) dv = MAXV;
         if (dv < MINV) dv = MINV;
         fm = (fv < 0) ? -fv : fv;
         dm = (dv < 0) ? -dv : dv;
         if (fm > MAXV) fm = MAXV;
         if (dm > MAXV) dm = MAXV;
         e.zf[i] = (fv == 0);
         e.dz[i] = (dv == 0);
         if (dv == 0) begin
            e.ex[i*W +: W] = 32'h7FFFFFFF;
            e.sg[i] = (fv < 0);
         end else if (fv == 0) begin
            e.ex[i*W +: W] = 32'h80000000;
            e.sg[i] = 1'b0;
         end else begin
            e.ex[i*W +: W] = 32'(mlog(fm) - mlog(dm));
            e.sg[i] = ((fv < 0) != (dv < 0));
         end
      end
      return e;
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFC000000;
         2:       return 32'($urandom_range(1, 1000));
         3:       return ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
         4:       return 32'($urandom) >> $urandom_range(0, 31);
         default: return 32'($urandom);
      endcase
   endfunction

   // Expected response is queued at the moment the beat is accepted.
   task automatic send(input logic [LN*W-1:0] f, input logic [LN*W-1:0] s, input logic m, input exp_t e);
      int  n;
      logic acc;
      n = 0;
      acc = 1'b0;
      valid_in = 1'b1;
      F = f;
      s_xi = s;
      mode = m;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = ready_in;
         @(posedge clk);
         #1;
         n++;
      end
      if (acc) exp_q.push_back(e);
      else check("send_timeout", 64'(n), 64'(0));
      valid_in = 1'b0;
   endtask

   task automatic send_rand();
      logic [LN*W-1:0] f, s;
      logic m;
      f = {rnd_word(), rnd_word()};
      s = {rnd_word(), rnd_word()};
      m = 1'($urandom_range(0, 1));
      send(f, s, m, model(f, s, m));
   endtask

   task automatic drain();
      int n;
      n = 0;
      ready_out = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      out_cnt = 0;
      stall_tb = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && valid_out && ready_out) begin
         out_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got exponent %h with no beat pending", exponent);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            for (int i = 0; i < LN; i++) begin
               check($sformatf("exponent[%0d]", i), 64'(exponent[i*W +: W]), 64'(e.ex[i*W +: W]));
               check($sformatf("sign[%0d]", i), 64'(result_sign[i]), 64'(e.sg[i]));
               check($sformatf("zero[%0d]", i), 64'(zero_flag[i]), 64'(e.zf[i]));
               check($sformatf("dbz[%0d]", i), 64'(dbz_flag[i]), 64'(e.dz[i]));
            end
         end
      end
      if (rst_n && valid_out && !ready_out) stall_tb++;
   end

   exp_t e1, e2, e3, e4, e5, e6;
   int   lat;
   bit   done;
   logic [LN*W-1:0] held;

   initial begin
      rst_n = 1'b0;
      valid_in = 1'b0;
      mode = 1'b0;
      F = '0;
      s_xi = '0;
      ready_out = 1'b1;
      done = 1'b0;
      #1;
      check("rst_valid_out", 64'(valid_out), 64'(0));
      check("rst_exponent", 64'(exponent), 64'(0));
      check("rst_flags", 64'({result_sign, zero_flag, dbz_flag}), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", 64'(ready_in), 64'(1));

      e1 = '{ex: {32'h05000000, 32'h0C000000}, sg: 2'b00, zf: 2'b00, dz: 2'b00};
      e2 = '{ex: {32'h04000000, 32'h08400000}, sg: 2'b01, zf: 2'b00, dz: 2'b00};
      e3 = '{ex: {32'h06000000, 32'h06000000}, sg: 2'b10, zf: 2'b00, dz: 2'b00};
      e4 = '{ex: {32'h80000000, 32'h7FFFFFFF}, sg: 2'b00, zf: 2'b10, dz: 2'b01};
      e5 = '{ex: {32'h7BFFFFFF, 32'h7FFFFFFF}, sg: 2'b10, zf: 2'b01, dz: 2'b01};
      e6 = '{ex: {32'h7FFFFFFF, 32'h00000000}, sg: 2'b10, zf: 2'b00, dz: 2'b10};

      send({32'h1C000000, 32'h20000000}, {32'h08000000, 32'h00000000}, 1'b0, e1);
      lat = 1;
      while (!valid_out && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(4));
      send({32'h18000000, 32'hBC000000}, {32'h08000000, 32'h0C000000}, 1'b0, e2);
      send({32'hE8000000, 32'h18000000}, {32'h08000000, 32'h08000000}, 1'b1, e3);
      send({32'h00000000, 32'h14000000}, {32'h04000000, 32'h00000000}, 1'b1, e4);
      send({32'h80000000, 32'h00000000}, {32'h00000001, 32'h00000000}, 1'b1, e5);
      send({32'hEC000000, 32'h7FFFFFFF}, {32'hFC000000, 32'h7FFFFFFF}, 1'b0, e6);
      drain();

      fork
         begin
            for (int b = 0; b < 200; b++) send_rand();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ready_out = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      do_reset();
      fork
         for (int b = 0; b < 8; b++) send_rand();
         begin
            int n;
            n = 0;
            while (!valid_out && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            repeat (2) begin
               @(posedge clk);
               #1;
            end
            ready_out = 1'b0;
            @(negedge clk);
            held = exponent;
            repeat (3) begin
               @(negedge clk);
               check("ready_in_stall", 64'(ready_in), 64'(0));
               check("valid_hold", 64'(valid_out), 64'(1));
               check("data_hold", 64'(exponent), 64'(held));
            end
            @(posedge clk);
            #1;
            ready_out = 1'b1;
         end
      join
      drain();
      check("beats_out", 64'(out_cnt), 64'(8));
      check("stall_cycles", 64'(stall_tb), 64'(4));
`ifdef DU_VEC_PERF_CNT_EN
      check("beat_cnt", 64'(beat_cnt), 64'(8));
      check("stall_cnt", 64'(stall_cnt), 64'(4));
`endif

      ready_out = 1'b0;
      send({32'h1C000000, 32'h20000000}, {32'h08000000, 32'h00000000}, 1'b0, e1);
      send({32'h18000000, 32'hBC000000}, {32'h08000000, 32'h0C000000}, 1'b0, e2);
      send({32'hE8000000, 32'h18000000}, {32'h08000000, 32'h08000000}, 1'b1, e3);
      lat = 0;
      while (!valid_out && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("valid_before_reset", 64'(valid_out), 64'(1));
      rst_n = 1'b0;
      exp_q.delete();
      out_cnt = 0;
      #1;
      check("midrst_valid_out", 64'(valid_out), 64'(0));
      check("midrst_exponent", 64'(exponent), 64'(0));
      check("midrst_flags", 64'({result_sign, zero_flag, dbz_flag}), 64'(0));
`ifdef DU_VEC_PERF_CNT_EN
      check("midrst_counters", 64'({beat_cnt, stall_cnt}), 64'(0));
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_out = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_midrst", 64'(ready_in), 64'(1));
      repeat (20) @(posedge clk);
      #1;
      check("no_stale_beats", 64'(out_cnt), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
